// File: rtl/stream_demux_1_4_if.sv
// Bundle of the upstream stream, the four registered channel outputs and
// the transfer counter for the 1:4 stream demultiplexer.
interface stream_demux_1_4_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [CNT_W-1:0] xfer_cnt;

  // Environment side: drives the upstream word and the downstream readies.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, d0, d1, d2, d3, out_valid, xfer_cnt
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, d0, d1, d2, d3, out_valid, xfer_cnt
  );
endinterface

// File: rtl/stream_demux_1_4.sv
// 1:4 stream demultiplexer: each channel is a one-entry buffer that can be
// drained and refilled in the same cycle; xfer_cnt counts delivered words.
module stream_demux_1_4 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  stream_demux_1_4_if.slave bus
);
  localparam int unsigned N_CH  = 4;
  localparam int unsigned HCNTW = 3;

  logic [WIDTH-1:0] data_q [N_CH];
  logic [WIDTH-1:0] data_d [N_CH];
  logic [N_CH-1:0]  valid_q;
  logic [N_CH-1:0]  valid_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             in_ready_c;
  logic             load_c;
  logic [N_CH-1:0]  out_hs_c;
  logic [HCNTW-1:0] hs_num_c;

  // A channel can take a word when empty or when it is being drained now.
  always_comb begin
    in_ready_c = ~valid_q[bus.in_sel] | bus.out_ready[bus.in_sel];
    load_c     = bus.in_valid & in_ready_c;
    out_hs_c   = valid_q & bus.out_ready;
    valid_d    = valid_q & ~out_hs_c;
    hs_num_c   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      data_d[i] = data_q[i];
      hs_num_c  = hs_num_c + HCNTW'(out_hs_c[i]);
      if (load_c && (bus.in_sel == 2'(i))) begin
        data_d[i]  = bus.in_data;
        valid_d[i] = 1'b1;
      end
    end
    cnt_d = cnt_q + CNT_W'(hs_num_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.d0        = data_q[0];
  assign bus.d1        = data_q[1];
  assign bus.d2        = data_q[2];
  assign bus.d3        = data_q[3];
  assign bus.out_valid = valid_q;
  assign bus.xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed scenarios followed by random traffic, each cycle checked against a
// per-channel buffer model held in the bench.
module tb_stream_demux_1_4;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_demux_1_4_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  stream_demux_1_4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] md [4];
  logic [3:0]       mv;
  int unsigned      mcnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                       input logic [3:0] r);
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  task automatic check_outputs();
    check("d0", 64'(bus.d0), 64'(md[0]));
    check("d1", 64'(bus.d1), 64'(md[1]));
    check("d2", 64'(bus.d2), 64'(md[2]));
    check("d3", 64'(bus.d3), 64'(md[3]));
    check("out_valid", 64'(bus.out_valid), 64'(mv));
    check("xfer_cnt", 64'(bus.xfer_cnt), 64'(CNT_W'(mcnt)));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) md[i] = '0;
    mv   = '0;
    mcnt = 0;
  endtask

  // One clock: check in_ready before the edge, advance the model, check after.
  task automatic step();
    logic [WIDTH-1:0] nd [4];
    logic [3:0]       nv;
    int unsigned      nc;
    logic             rdy;
    #2;
    rdy = !mv[bus.in_sel] || bus.out_ready[bus.in_sel];
    check("in_ready", 64'(bus.in_ready), 64'(rdy));
    nd = md;
    nv = mv;
    nc = mcnt;
    for (int i = 0; i < 4; i++) begin
      if (mv[i] && bus.out_ready[i]) begin
        nv[i] = 1'b0;
        nc++;
      end
    end
    if (bus.in_valid && rdy) begin
      nd[bus.in_sel] = bus.in_data;
      nv[bus.in_sel] = 1'b1;
    end
    nc = nc % (32'd1 << CNT_W);
    @(posedge clk);
    #1;
    md   = nd;
    mv   = nv;
    mcnt = nc;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 2'd0, '0, 4'b0000);
    model_clear();
    #1;
    check_outputs();
    check("in_ready_rst", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Routing: one word to each channel, nothing drained.
    drive(1'b1, 2'd0, 4'ha, 4'b0000); step();
    drive(1'b1, 2'd1, 4'hb, 4'b0000); step();
    drive(1'b1, 2'd2, 4'hc, 4'b0000); step();
    drive(1'b1, 2'd3, 4'hd, 4'b0000); step();
    check("route_d0", 64'(bus.d0), 64'(4'ha));
    check("route_d3", 64'(bus.d3), 64'(4'hd));
    check("route_valid", 64'(bus.out_valid), 64'(4'b1111));
    check("route_cnt", 64'(bus.xfer_cnt), 64'(0));

    // Multi-drain: all four channels delivered in one cycle.
    drive(1'b0, 2'd0, 4'h0, 4'b1111); step();
    check("drain_valid", 64'(bus.out_valid), 64'(4'b0000));
    check("drain_cnt", 64'(bus.xfer_cnt), 64'(4));

    // Pass-through: drain and refill channel 0 in the same cycle.
    do_reset();
    drive(1'b1, 2'd0, 4'h5, 4'b0000); step();
    drive(1'b1, 2'd0, 4'h9, 4'b0001); step();
    check("pass_valid0", 64'(bus.out_valid[0]), 64'(1));
    check("pass_d0", 64'(bus.d0), 64'(4'h9));
    check("pass_cnt", 64'(bus.xfer_cnt), 64'(1));

    // Backpressure on channel 2.
    drive(1'b1, 2'd2, 4'h3, 4'b0000); step();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'd2, 4'h7, 4'b0000); step();
      check("bp_ready", 64'(bus.in_ready), 64'(0));
      check("bp_d2", 64'(bus.d2), 64'(4'h3));
    end
    drive(1'b1, 2'd1, 4'h7, 4'b0000);
    #2;
    check("bp_other_ready", 64'(bus.in_ready), 64'(1));
    step();

    // Unknown data is carried through unchanged.
    drive(1'b1, 2'd3, 'x, 4'b0000); step();
    check("x_d3", 64'(bus.d3), 64'(4'bxxxx));

    // Asynchronous reset between edges with every channel full.
    check("full_before_rst", 64'(bus.out_valid), 64'(4'b1111));
    drive(1'b1, 2'd0, 4'h5, 4'b1111);
    #3;
    rst = 1'b1;
    #1;
    model_clear();
    check_outputs();
    check("rst_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    check("rst_no_hs_valid", 64'(bus.out_valid), 64'(0));
    check("rst_no_hs_cnt", 64'(bus.xfer_cnt), 64'(0));
    #3;
    rst = 1'b0;
    drive(1'b1, 2'd2, 4'h6, 4'b0000); step();
    check("resume_d2", 64'(bus.d2), 64'(4'h6));

    // Counter wrap: stream channel 0 until 254, then drain three at once.
    do_reset();
    for (int k = 0; k < 1000 && mcnt != 254; k++) begin
      drive(1'b1, 2'd0, WIDTH'($urandom), 4'b0001); step();
    end
    check("wrap_pre", 64'(bus.xfer_cnt), 64'(254));
    drive(1'b1, 2'd1, 4'h1, 4'b0000); step();
    drive(1'b1, 2'd2, 4'h2, 4'b0000); step();
    drive(1'b0, 2'd0, 4'h0, 4'b0111); step();
    check("wrap_cnt", 64'(bus.xfer_cnt), 64'(1));

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), WIDTH'($urandom),
            4'($urandom));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
